fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core: holds PCF, issues requests to instruction memory and captures returned words.
- Drives the IF/ID pipeline register whose InstrD[6:0] feeds the control decoder in ID.
- Handles variable-latency memory, ID stalls, ID flushes and EX-stage branch redirects.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, reset/bubble constants,
// base opcodes used by the ID decoder, and the fetch-stage state type.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, a bubble, or holds.
module if_id_reg #(
   parameter int unsigned XLEN      = riscv_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            i_wr,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_plus4,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4,
   output logic            o_valid
);

   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_plus4;
   logic            r_valid;

   // A bubble keeps the PC fields so the hazard unit still sees a sane PCD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr    <= NOP_INSTR;
         r_pc       <= '0;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (clr) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (en) begin
         if (i_wr) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
         end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
         end
      end
   end

   assign o_instr    = r_instr;
   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PCF, single-outstanding imem handshake,
// stall hold buffer, redirect with stale-response drop, and IF/ID register.
module fetch_unit #(
   parameter int unsigned XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   import riscv_pkg::*;

   fetch_state_e    r_state, w_state_n;
   logic [XLEN-1:0] r_pcf, w_pcf_n, w_pcf_plus4;
   logic            r_drop, w_drop_n;
   logic [31:0]     r_hold, w_hold_n;
   logic            w_hs;
   logic            w_wr;
   logic [31:0]     w_wr_instr;

   assign w_pcf_plus4 = r_pcf + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= REQ;
         r_pcf   <= RESET_PC;
         r_drop  <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_n;
         r_pcf   <= w_pcf_n;
         r_drop  <= w_drop_n;
         r_hold  <= w_hold_n;
      end
   end

   // A stale response is consumed whenever it shows up, so a redirect issued
   // from REQ (old request still in flight) cannot eat the next real response.
   always_comb begin
      imem_req   = (r_state == REQ) && !StallF && !rst;
      imem_addr  = r_pcf;
      w_hs       = imem_req && imem_ready;
      w_state_n  = r_state;
      w_pcf_n    = r_pcf;
      w_drop_n   = r_drop;
      w_hold_n   = r_hold;
      w_wr       = 1'b0;
      w_wr_instr = imem_rdata;
      if (PCSrcE) begin
         w_state_n = REQ;
         w_pcf_n   = PCTargetE & ~XLEN'(3);
         w_drop_n  = (!imem_rvalid && (r_drop || (r_state == WAIT))) || w_hs;
      end else if (imem_rvalid && r_drop) begin
         w_drop_n  = 1'b0;
         w_state_n = w_hs ? WAIT : REQ;
      end else begin
         unique case (r_state)
            REQ: if (w_hs) w_state_n = WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  if (!StallD) begin
                     w_wr      = 1'b1;
                     w_pcf_n   = w_pcf_plus4;
                     w_state_n = REQ;
                  end else begin
                     w_hold_n  = imem_rdata;
                     w_state_n = HOLD;
                  end
               end
            end
            HOLD: begin
               w_wr_instr = r_hold;
               if (!StallD) begin
                  w_wr      = 1'b1;
                  w_pcf_n   = w_pcf_plus4;
                  w_state_n = REQ;
               end
            end
            default: w_state_n = REQ;
         endcase
      end
   end

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .en         (!StallD),
      .clr        (FlushD),
      .i_wr       (w_wr),
      .i_instr    (w_wr_instr),
      .i_pc       (r_pcf),
      .i_pc_plus4 (w_pcf_plus4),
      .o_instr    (InstrD),
      .o_pc       (PCD),
      .o_pc_plus4 (PCPlus4D),
      .o_valid    (ValidD)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// hazards against a transaction-level fetch model and a tb-owned memory.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;

   logic        rst2, ready2, rvalid2, zero2;
   logic [31:0] rdata2, tgt2;
   logic        req2, valid2;
   logic [31:0] addr2, instr2, pcd2, pcp2;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // fetch model
   logic [31:0] m_pc, m_held, m_instr, m_pcd, m_pcp4;
   logic        m_inflight, m_held_v, m_stale, m_valid;
   // memory model
   logic        mp;
   logic [31:0] maddr;
   int unsigned mcnt;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .rst(rst2), .StallF(zero2), .StallD(zero2), .FlushD(zero2),
      .PCSrcE(zero2), .PCTargetE(tgt2), .imem_req(req2), .imem_addr(addr2),
      .imem_ready(ready2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
      .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pcp2), .ValidD(valid2)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h0050_0093 ^ (a << 7);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit sf, input bit sd, input bit fd,
                      input bit ps, input logic [31:0] tg, input bit rdy,
                      input int unsigned lat);
      logic        exp_req, hs, wr;
      logic [31:0] pc_old, wd;
      @(negedge clk);
      rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tg;
      imem_rvalid = mp && (mcnt == 0);
      imem_rdata  = imem_rvalid ? word(maddr) : $urandom;
      imem_ready  = rdy && !mp;
      #1;
      exp_req = !r && !m_inflight && !m_held_v && !sf;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (!r) chk("imem_addr", imem_addr, m_pc);
      hs = exp_req && imem_ready;
      @(posedge clk);
      pc_old = m_pc;
      wr = 1'b0;
      wd = '0;
      if (r) begin
         m_pc = '0; m_inflight = 0; m_held_v = 0; m_stale = 0;
         m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 0;
         mp = 0;
      end else begin
         if (imem_rvalid && m_stale) m_stale = 0;
         else if (imem_rvalid) begin
            m_inflight = 0;
            if (!ps) begin
               if (!sd) begin wr = 1; wd = imem_rdata; end
               else begin m_held_v = 1; m_held = imem_rdata; end
            end
         end else if (m_held_v && !sd && !ps) begin
            wr = 1; wd = m_held; m_held_v = 0;
         end
         if (ps) begin
            if (m_inflight || hs) m_stale = 1;
            m_inflight = 0; m_held_v = 0; m_pc = tg & ~32'd3;
         end else begin
            if (hs) m_inflight = 1;
            if (wr) m_pc = pc_old + 32'd4;
         end
         if (fd) begin m_instr = NOP; m_valid = 0; end
         else if (!sd) begin
            if (wr) begin m_instr = wd; m_pcd = pc_old; m_pcp4 = pc_old + 32'd4; m_valid = 1; end
            else begin m_instr = NOP; m_valid = 0; end
         end
         if (imem_rvalid) mp = 0;
         else if (mp) mcnt--;
         if (hs) begin mp = 1; maddr = pc_old; mcnt = lat; end
      end
      #1;
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_pcp4);
      chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
   endtask

   // shorthand: plain cycle with memory ready and given latency
   task automatic go(input bit sf, input bit sd, input int unsigned lat);
      cyc(0, sf, sd, 0, 0, '0, 1, lat);
   endtask

   initial begin
      rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
      rst2 = 1; ready2 = 0; rvalid2 = 0; rdata2 = '0; zero2 = 0; tgt2 = '0;
      m_pc = '0; m_inflight = 0; m_held_v = 0; m_stale = 0; m_held = '0;
      m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 0;
      mp = 0; maddr = '0; mcnt = 0;

      // reset
      cyc(1, 0, 0, 0, 0, '0, 0, 0);
      cyc(1, 0, 0, 0, 0, '0, 0, 0);
      chk("rst_instr", InstrD, 32'h0000_0013);
      chk("rst_valid", {31'b0, ValidD}, 32'd0);

      // first fetch, zero-latency memory
      go(0, 0, 0);
      go(0, 0, 0);
      chk("first_instr", InstrD, 32'h0050_0093);
      chk("first_pcd", PCD, 32'd0);
      chk("first_pcp4", PCPlus4D, 32'd4);
      chk("first_valid", {31'b0, ValidD}, 32'd1);
      chk("addr_after_first", imem_addr, 32'd4);

      // StallD across the response at 8
      go(0, 0, 0); go(0, 0, 0);
      go(0, 0, 0);
      go(0, 1, 0); go(0, 1, 0); go(0, 1, 0);
      chk("hold_pcd", PCD, 32'd4);
      chk("hold_valid", {31'b0, ValidD}, 32'd0);
      go(0, 0, 0);
      chk("hold_rel_instr", InstrD, word(32'd8));
      chk("hold_rel_pcd", PCD, 32'd8);
      chk("hold_rel_addr", imem_addr, 32'd12);

      // redirect while waiting on addr 16
      go(0, 0, 0); go(0, 0, 0);
      go(0, 0, 3);
      cyc(0, 0, 0, 1, 1, 32'h0000_0103, 1, 0);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      for (int i = 0; i < 3; i++) begin
         go(1, 0, 0);
         chk("redir_drop_valid", {31'b0, ValidD}, 32'd0);
      end
      go(0, 0, 0); go(0, 0, 0);
      chk("redir_instr", InstrD, word(32'h100));
      chk("redir_pcd", PCD, 32'h100);

      // flush coincident with response under StallD
      go(0, 0, 0);
      cyc(0, 0, 1, 1, 0, '0, 1, 0);
      chk("flush_instr", InstrD, 32'h0000_0013);
      chk("flush_valid", {31'b0, ValidD}, 32'd0);
      go(0, 0, 0);
      chk("flush_rel_pcd", PCD, 32'h104);

      // reset while waiting
      go(0, 0, 3);
      cyc(1, 0, 0, 0, 0, '0, 1, 0);
      chk("rstw_pcd", PCD, 32'd0);
      chk("rstw_req", {31'b0, imem_req}, 32'd0);
      cyc(1, 0, 0, 0, 0, '0, 1, 0);
      cyc(0, 1, 0, 0, 0, '0, 0, 0);
      chk("rstw_addr", imem_addr, 32'd0);

      // randomized hazards
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0),
             ($urandom_range(3) == 0), ($urandom_range(7) == 0),
             ($urandom_range(9) == 0), $urandom,
             ($urandom_range(3) != 0), $urandom_range(3));
      end

      // PC wrap with RESET_PC at top of address space
      @(negedge clk); rst2 = 1;
      @(negedge clk); rst2 = 0; ready2 = 1;
      #1;
      chk("wrap_req", {31'b0, req2}, 32'd1);
      chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      @(negedge clk); ready2 = 0; rvalid2 = 1; rdata2 = 32'h0010_0113;
      @(posedge clk); #1;
      chk("wrap_instr", instr2, 32'h0010_0113);
      chk("wrap_pcd", pcd2, 32'hFFFF_FFFC);
      chk("wrap_pcp4", pcp2, 32'd0);
      chk("wrap_next_addr", addr2, 32'd0);
      @(negedge clk); rvalid2 = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
